// File: rtl/fetch_seq_ctrl.sv
// Multi-cycle instruction-fetch sequencer: owns the architectural PC and walks
// each instruction through FETCH -> ISSUE -> RESOLVE, with timeout-error and halt states.
module fetch_seq_ctrl #(
    parameter logic [29:0] RESET_PC     = 30'h0000_0C00,
    parameter int unsigned IMEM_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [29:0] inst_pc,
    input  logic        inst_ready,
    input  logic        resolve_valid,
    input  logic        jumpCtr,
    input  logic        nPC_sel,
    input  logic        zero,
    input  logic [15:0] imm,
    input  logic [25:0] tarAddr,
    input  logic        halt,
    output logic [29:0] pc,
    output logic [31:0] instr_count,
    output logic        fetch_err,
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_RESOLVE = 3'd2,
        ST_HALTED  = 3'd3,
        ST_ERROR   = 3'd4
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(IMEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [29:0] inst_pc_q, inst_pc_d;
    logic [31:0] count_q, count_d;
    logic        err_q, err_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;

    // Jump beats taken branch beats sequential; all arithmetic wraps mod 2^30.
    function automatic logic [29:0] calc_next_pc(
        input logic [29:0] cur_pc,
        input logic        jump,
        input logic        branch,
        input logic        alu_zero,
        input logic [15:0] offset,
        input logic [25:0] target
    );
        logic [29:0] seq_pc;
        seq_pc = cur_pc + 30'd1;
        if (jump) begin
            calc_next_pc = {cur_pc[29:26], target};
        end else if (branch && alu_zero) begin
            calc_next_pc = seq_pc + {{14{offset[15]}}, offset};
        end else begin
            calc_next_pc = seq_pc;
        end
    endfunction

    // Next-state, datapath updates and next-cycle output decode.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        count_d   = count_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    tmo_d     = 8'd0;
                    state_d   = ST_ISSUE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    tmo_d   = 8'd0;
                    state_d = ST_ERROR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_ISSUE: begin
                if (inst_ready) begin
                    state_d = ST_RESOLVE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_RESOLVE: begin
                if (resolve_valid) begin
                    pc_d    = calc_next_pc(inst_pc_q, jumpCtr, nPC_sel, zero, imm, tarAddr);
                    count_d = count_q + 32'd1;
                    state_d = halt ? ST_HALTED : ST_FETCH;
                end else begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            ST_ERROR:  state_d = ST_ERROR;
            default: begin
                // Corrupted state encoding is treated as a fault.
                err_d   = 1'b1;
                state_d = ST_ERROR;
            end
        endcase
        req_d    = (state_d == ST_FETCH);
        valid_d  = (state_d == ST_ISSUE);
        halted_d = (state_d == ST_HALTED);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            inst_pc_q <= 30'd0;
            count_q   <= 32'd0;
            err_q     <= 1'b0;
            tmo_q     <= 8'd0;
            req_q     <= 1'b1;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            count_q   <= count_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign inst_valid  = valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign pc          = pc_q;
    assign instr_count = count_q;
    assign fetch_err   = err_q;
    assign halted      = halted_q;

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
Multi-cycle instruction-fetch sequencer for the MIPS core. Owns the architectural PC (30-bit word address) and runs one instruction at a time: fetch from instruction memory, hand off to decode, wait for execute to resolve control flow, then commit the next PC. Next-PC rules match the core's next-PC datapath (sequential, taken branch, jump) and add a memory-timeout error path and a halt state.

Parameters:
RESET_PC, 30'h0000_0C00, word address loaded on reset (byte address 0x3000)
IMEM_TIMEOUT, 8, max FETCH cycles without imem_ack before error (range 1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
imem_req  out  1  fetch request, high only in FETCH
imem_addr  out  30  word address, equals pc
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  instruction word
inst_valid  out  1  instruction available to decode
inst  out  32  captured instruction
inst_pc  out  30  word address of inst
inst_ready  in  1  decode accepts inst
resolve_valid  in  1  execute reports control outcome for the issued instruction
jumpCtr  in  1  jump taken
nPC_sel  in  1  instruction is a branch
zero  in  1  ALU zero flag
imm  in  16  branch offset (words, signed)
tarAddr  in  26  jump target field
halt  in  1  stop after current instruction (sampled with resolve_valid)
pc  out  30  architectural PC
instr_count  out  32  retired-instruction counter
fetch_err  out  1  sticky imem timeout flag
halted  out  1  high in HALTED

Behaviour:
- States: FETCH, ISSUE, RESOLVE, HALTED, ERROR. Registered outputs, Moore decode of state.
- Reset (any state, any cycle, overrides all inputs): state=FETCH, pc=RESET_PC, inst=0, inst_pc=0, instr_count=0, fetch_err=0, timeout counter=0. Cycle after reset release: imem_req=1, imem_addr=RESET_PC.
- FETCH: imem_req=1. If imem_ack: capture inst<=imem_rdata, inst_pc<=pc, counter<=0, go ISSUE. Else counter+1; if counter reaches IMEM_TIMEOUT-1 with no ack -> ERROR (i.e. IMEM_TIMEOUT request cycles without ack). Ack on the final allowed cycle wins over timeout.
- imem_ack outside FETCH ignored.
- ISSUE: inst_valid=1, inst/inst_pc stable. On inst_ready -> RESOLVE. No timeout.
- RESOLVE: waits indefinitely for resolve_valid. On resolve_valid: pc<=next_pc, instr_count+1 (wraps mod 2^32); if halt -> HALTED else FETCH.
- next_pc (mod 2^30, wraps silently), priority order:
  jumpCtr=1 -> {pc[29:26], tarAddr}
  nPC_sel=1 and zero=1 -> pc + 1 + sign_extend30(imm)
  otherwise -> pc + 1
  pc here is the address of the resolving instruction (= inst_pc).
- HALTED: halted=1, no requests, pc frozen; exit only via rst.
- ERROR: fetch_err=1 (sticky), no requests, pc holds faulting address; exit only via rst.
- imem_req, inst_valid, halted are 0 in every state not listed for them. 
- Minimum loop with zero-wait memory/decode/execute: 3 cycles per instruction.

Test Plan:
- Reset, ack on first FETCH cycle with rdata 32'h2408_0005, inst_ready and resolve_valid immediate, no control -> imem_addr 30'h0C00, inst_pc 30'h0C00, next pc 30'h0C01, instr_count 1, next imem_req 3 cycles after first.
- At pc 30'h0C05: nPC_sel=1, zero=1, imm 16'hFFFF -> pc 30'h0C05; same with zero=0 -> pc 30'h0C06; imm 16'h0010 taken -> 30'h0C16.
- At pc 30'h0C00: jumpCtr=1, nPC_sel=1, zero=1, tarAddr 26'h0000100 -> pc 30'h0000100 (jump priority).
- pc 30'h3FFF_FFFF sequential -> pc 0; instr_count 32'hFFFF_FFFF increments -> 0.
- No ack for 8 FETCH cycles -> fetch_err=1, imem_req=0 from cycle 9, pc unchanged; ack arriving on cycle 8 instead -> ISSUE, fetch_err=0.
- halt=1 with resolve_valid -> pc updated, halted=1, no further imem_req; rst asserted mid-ISSUE and mid-HALTED -> next cycle FETCH, pc 30'h0C00, all flags 0.
